keypad_encoder: RTL and testbench
=================================

Name: keypad_encoder

Overview:
- Scans a 4x4 matrix keypad, debounces the sampled matrix and encodes one pressed key into a 4-bit code.
- Input-side counterpart of the counter/7-segment display path: keys enter values, displays show them.
- Delivers each new key press as a single event on a valid/ready handshake to the processor front end.
- Reports the currently held key, and whether more than one key is down.

Parameters:
- ROWS, 4, number of keypad rows sensed.
- COLS, 4, number of keypad columns driven.
- SCAN_DIV, 50000, clk cycles each column is driven (1 ms at 50 MHz).
- DEB_SCANS, 4, consecutive identical sweeps needed to accept a change.
- REPEAT_SCANS, 250, sweeps between auto-repeat events (used only with KEYPAD_REPEAT_EN).

Ports:
- clk  input  1  50 MHz system clock.
- rst_n  input  1  asynchronous active-low reset.
- row_in  input  ROWS  keypad rows, active-low, externally pulled up, asynchronous.
- col_out  output  COLS  column drive, active-low, one-hot-low.
- key_code  output  4  encoded key, row*COLS+col.
- key_valid  output  1  event pending.
- key_ready  input  1  consumer accepts event.
- key_held  output  1  debounced single key currently down.
- multi_key  output  1  debounced state has two or more keys down.
- overrun  output  1  one-cycle pulse when an event is dropped.

Behaviour:
- One clock, clk; reset asynchronous active-low on rst_n.
- Reset values:
  - col_out all ones.
  - key_code 0; key_valid, key_held, multi_key, overrun all 0.
  - Debounce state = NO_KEY; scan column index 0.
- row_in passes through a 2-flop synchronizer before any use.
- Scan FSM states:
  - DRIVE: col_out drives column c low; dwell counter runs 0..SCAN_DIV-1.
  - SAMPLE: entered at dwell end; latches the synchronized rows for column c into a ROWS*COLS sweep image; c advances.
  - EVAL: entered after column COLS-1 is sampled; takes 1 cycle, then returns to DRIVE with c=0.
- First DRIVE begins on the first clk edge after rst_n deasserts.
- Sweep period: COLS*(SCAN_DIV+1)+1 cycles.
- EVAL classification:
  - Zero bits set -> NO_KEY.
  - Exactly one bit set -> that key.
  - Two or more bits set -> MULTI.
- Debounce rule:
  - A candidate equal to the previous sweep's candidate increments the match count; otherwise the count reloads to 1.
  - When the count reaches DEB_SCANS, the candidate becomes the stable state.
- Outputs from the stable state:
  - key_held = 1 while stable is a single key.
  - multi_key = 1 while stable is MULTI.
  - key_code follows the held key only when no event is pending.
- Event generation:
  - An event fires only on a stable transition into a single key from NO_KEY or MULTI.
  - A key-to-key change without passing through NO_KEY also fires.
  - Release never fires.
- Handshake:
  - key_valid rises on the cycle after the qualifying EVAL.
  - key_code is held constant while key_valid=1.
  - Transfer occurs when key_valid and key_ready are both 1; key_valid falls on the next cycle.
  - key_ready has no effect while key_valid=0.
- Overrun: a new event while key_valid=1 and not transferring in that cycle is dropped, and overrun pulses for 1 cycle. The oldest event is kept.
- Simultaneous transfer and new event: the new event is loaded and key_valid stays 1.
- rst_n asserted mid-operation discards any pending event and the sweep image immediately.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined:
  - While a single key stays stable, a sweep counter runs.
  - Every REPEAT_SCANS sweeps it generates a repeat event with the same code.
  - Repeat events use the same handshake and overrun rules.
  - The counter clears on any stable-state change.
- Undefined: exactly one event per press; the repeat counter logic is absent.

Decomposition:
- Package keypad_pkg holds:
  - Scan state enum (DRIVE, SAMPLE, EVAL).
  - Debounced-state enum (NO_KEY, SINGLE, MULTI).
  - KEY_CODE_W = 4.
  - Code-from-row/col helper function.
- One natural sub-module: keypad_sync, a parameterized-width 2-flop synchronizer for row_in.

Test Plan (SCAN_DIV=4, DEB_SCANS=2, REPEAT_SCANS=3; sweep = 21 cycles):
- Reset: rst_n=0 -> col_out=4'b1111, key_valid=0. Release rst_n -> col_out=4'b1110 on the next edge, and it rotates 1101/1011/0111 every 5 cycles.
- Press row2/col1 steadily:
  - key_code=9 and key_valid=1 within 3 sweeps; key_held=1.
  - key_ready=1 -> key_valid=0 on the next cycle.
  - No further event while held (macro off). With macro on, a repeat code 9 event follows every 3 sweeps.
- Bounce row0/col0 every 3 cycles for 60 cycles, then hold -> exactly one event, code 0.
- Hold row1/col0 and row1/col3 together -> multi_key=1, no event. Release col3 -> one event with code 4.
- Backpressure with key_ready=0:
  - Press/release code 3, then press code 5 -> key_code stays 3, and overrun pulses once at code 5 qualification.
  - Then key_ready=1 -> code 3 is transferred and no code 5 event follows.
- Assert rst_n=0 while key_valid=1 -> key_valid=0 and col_out=4'b1111 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared types and helpers for the 4x4 keypad encoder.
//   scan_state_e : column scan sequencer states (DRIVE, SAMPLE, EVAL)
//   deb_state_e  : classification of a sweep / debounced keypad state
//   KEY_CODE_W   : width of the encoded key (row*COLS+col)
//   f_key_code   : key code from a row/column pair
// -----------------------------------------------------------------------------
package keypad_pkg;

  localparam int KEY_CODE_W = 4;

  typedef enum logic [1:0] {
    DRIVE  = 2'd0,
    SAMPLE = 2'd1,
    EVAL   = 2'd2
  } scan_state_e;

  typedef enum logic [1:0] {
    NO_KEY = 2'd0,
    SINGLE = 2'd1,
    MULTI  = 2'd2
  } deb_state_e;

  // Code of the key at (row, col) on a keypad with 'cols' columns.
  function automatic logic [KEY_CODE_W-1:0] f_key_code(input int unsigned row,
                                                       input int unsigned col,
                                                       input int unsigned cols);
    int unsigned w_idx;
    w_idx = (row * cols) + col;
    return w_idx[KEY_CODE_W-1:0];
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// -----------------------------------------------------------------------------
// keypad_sync
// Two-flop synchronizer for the asynchronous, active-low keypad row lines.
// Resets to all ones (no row pulled low = no key).
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   i_d   : asynchronous input bus
//   o_q   : synchronized output bus
// -----------------------------------------------------------------------------
module keypad_sync
  import keypad_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  // Metastability filter: two back-to-back flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= {W{1'b1}};
      r_sync <= {W{1'b1}};
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_encoder.sv
// -----------------------------------------------------------------------------
// keypad_encoder
// Scans a ROWS x COLS matrix keypad, debounces whole sweeps and delivers each
// new single-key press as one event on a valid/ready handshake.
// Optional feature: define KEYPAD_REPEAT_EN to emit auto-repeat events every
// REPEAT_SCANS sweeps while a single key stays held.
// Ports:
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   row_in    : keypad rows, active-low, asynchronous
//   col_out   : column drive, active-low one-hot (all ones while evaluating)
//   key_code  : encoded key row*COLS+col, frozen while key_valid=1
//   key_valid : event pending
//   key_ready : consumer accepts the pending event
//   key_held  : debounced state is exactly one key
//   multi_key : debounced state has two or more keys
//   overrun   : one-cycle pulse when an event is dropped
// -----------------------------------------------------------------------------
module keypad_encoder
  import keypad_pkg::*;
#(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int DEB_SCANS    = 4,
  parameter int REPEAT_SCANS = 250
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ROWS-1:0]       row_in,
  output logic [COLS-1:0]       col_out,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_valid,
  input  logic                  key_ready,
  output logic                  key_held,
  output logic                  multi_key,
  output logic                  overrun
);

  localparam int NB = ROWS * COLS;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int MW = $clog2(DEB_SCANS + 1);

  logic [ROWS-1:0]       w_rows_sync;
  logic                  r_run;
  scan_state_e           r_state,  w_state_nxt;
  logic [CW-1:0]         r_col,    w_col_nxt;
  logic [DW-1:0]         r_dwell,  w_dwell_nxt;
  logic [COLS-1:0]       r_col_out, w_col_out_nxt;
  logic [NB-1:0]         r_img,    w_img_nxt;
  logic [1:0]            w_hits;
  logic [KEY_CODE_W-1:0] w_code_one;
  deb_state_e            w_cand_kind;
  logic [KEY_CODE_W-1:0] w_cand_code;
  deb_state_e            r_cand_kind, r_stable_kind, w_stable_kind_nxt;
  logic [KEY_CODE_W-1:0] r_cand_code, r_stable_code, w_stable_code_nxt;
  logic [MW-1:0]         r_match,  w_match_nxt;
  logic                  w_eval, w_change, w_press, w_repeat, w_fire, w_xfer;
  logic                  r_valid,  w_valid_nxt;
  logic [KEY_CODE_W-1:0] r_code,   w_code_nxt;
  logic                  r_ovr,    w_ovr_nxt;
  logic                  r_held,   r_multi;

  keypad_sync #(.W(ROWS)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (row_in),
    .o_q   (w_rows_sync)
  );

  // Scan sequencer state register; r_run delays the first DRIVE to the edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run     <= 1'b0;
      r_state   <= DRIVE;
      r_col     <= {CW{1'b0}};
      r_dwell   <= {DW{1'b0}};
      r_col_out <= {COLS{1'b1}};
      r_img     <= {NB{1'b0}};
    end else begin
      r_run     <= 1'b1;
      r_state   <= w_state_nxt;
      r_col     <= w_col_nxt;
      r_dwell   <= w_dwell_nxt;
      r_col_out <= w_col_out_nxt;
      r_img     <= w_img_nxt;
    end
  end

  // Scan sequencer next state, column drive and sweep image capture.
  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_dwell_nxt = r_dwell;
    w_img_nxt   = r_img;
    if (!r_run) begin
      w_state_nxt = DRIVE;
      w_col_nxt   = {CW{1'b0}};
      w_dwell_nxt = {DW{1'b0}};
    end else begin
      case (r_state)
        DRIVE: begin
          if (r_dwell == DW'(SCAN_DIV - 1)) begin
            w_state_nxt = SAMPLE;
            w_dwell_nxt = {DW{1'b0}};
          end else begin
            w_dwell_nxt = r_dwell + DW'(1);
          end
        end
        SAMPLE: begin
          // Rows are active-low: a low row under the driven column is a pressed key.
          for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
              if (CW'(c) == r_col) begin
                w_img_nxt[r*COLS + c] = ~w_rows_sync[r];
              end else begin
                w_img_nxt[r*COLS + c] = r_img[r*COLS + c];
              end
            end
          end
          if (r_col == CW'(COLS - 1)) begin
            w_state_nxt = EVAL;
            w_col_nxt   = {CW{1'b0}};
          end else begin
            w_state_nxt = DRIVE;
            w_col_nxt   = r_col + CW'(1);
          end
        end
        EVAL: begin
          w_state_nxt = DRIVE;
          w_col_nxt   = {CW{1'b0}};
        end
        default: begin
          w_state_nxt = DRIVE;
          w_col_nxt   = {CW{1'b0}};
          w_dwell_nxt = {DW{1'b0}};
        end
      endcase
    end
    // Columns are released (all high) during the evaluation cycle.
    if (w_state_nxt == EVAL) begin
      w_col_out_nxt = {COLS{1'b1}};
    end else begin
      w_col_out_nxt = ~(COLS'(1'b1) << w_col_nxt);
    end
  end

  // Sweep classification: count set bits saturating at two, remember the last set key.
  always_comb begin
    w_hits     = 2'd0;
    w_code_one = {KEY_CODE_W{1'b0}};
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (r_img[r*COLS + c]) begin
          w_hits     = (w_hits == 2'd2) ? 2'd2 : (w_hits + 2'd1);
          w_code_one = f_key_code(r, c, COLS);
        end else begin
          w_hits     = w_hits;
        end
      end
    end
    case (w_hits)
      2'd0: begin
        w_cand_kind = NO_KEY;
        w_cand_code = {KEY_CODE_W{1'b0}};
      end
      2'd1: begin
        w_cand_kind = SINGLE;
        w_cand_code = w_code_one;
      end
      default: begin
        w_cand_kind = MULTI;
        w_cand_code = {KEY_CODE_W{1'b0}};
      end
    endcase
  end

  // Debounce: candidate must repeat for DEB_SCANS sweeps before becoming stable.
  always_comb begin
    w_eval            = r_run && (r_state == EVAL);
    w_stable_kind_nxt = r_stable_kind;
    w_stable_code_nxt = r_stable_code;
    if ((w_cand_kind == r_cand_kind) && (w_cand_code == r_cand_code)) begin
      w_match_nxt = (r_match >= MW'(DEB_SCANS)) ? r_match : (r_match + MW'(1));
    end else begin
      w_match_nxt = MW'(1);
    end
    if (w_eval && (w_match_nxt >= MW'(DEB_SCANS))) begin
      w_stable_kind_nxt = w_cand_kind;
      w_stable_code_nxt = w_cand_code;
    end else begin
      w_stable_kind_nxt = r_stable_kind;
    end
    w_change = w_eval && ((w_stable_kind_nxt != r_stable_kind) ||
                          (w_stable_code_nxt != r_stable_code));
    // Any change that lands on a single key is a press (release never is).
    w_press  = w_change && (w_stable_kind_nxt == SINGLE);
  end

  // Debounce state registers and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cand_kind   <= NO_KEY;
      r_cand_code   <= {KEY_CODE_W{1'b0}};
      r_match       <= {MW{1'b0}};
      r_stable_kind <= NO_KEY;
      r_stable_code <= {KEY_CODE_W{1'b0}};
      r_held        <= 1'b0;
      r_multi       <= 1'b0;
    end else if (w_eval) begin
      r_cand_kind   <= w_cand_kind;
      r_cand_code   <= w_cand_code;
      r_match       <= w_match_nxt;
      r_stable_kind <= w_stable_kind_nxt;
      r_stable_code <= w_stable_code_nxt;
      r_held        <= (w_stable_kind_nxt == SINGLE);
      r_multi       <= (w_stable_kind_nxt == MULTI);
    end else begin
      r_match       <= r_match;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  logic [RW-1:0] r_rep_cnt, w_rep_cnt_nxt;

  // Auto-repeat sweep counter; restarts on any stable-state change.
  always_comb begin
    w_rep_cnt_nxt = r_rep_cnt;
    w_repeat      = 1'b0;
    if (w_eval) begin
      if (w_change || (r_stable_kind != SINGLE)) begin
        w_rep_cnt_nxt = {RW{1'b0}};
      end else if (r_rep_cnt == RW'(REPEAT_SCANS - 1)) begin
        w_rep_cnt_nxt = {RW{1'b0}};
        w_repeat      = 1'b1;
      end else begin
        w_rep_cnt_nxt = r_rep_cnt + RW'(1);
      end
    end else begin
      w_rep_cnt_nxt = r_rep_cnt;
    end
  end

  // Auto-repeat counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rep_cnt <= {RW{1'b0}};
    end else begin
      r_rep_cnt <= w_rep_cnt_nxt;
    end
  end
`else
  assign w_repeat = 1'b0;
`endif

  // Event handshake: keep the oldest event, flag drops, reload on simultaneous transfer.
  always_comb begin
    w_fire      = w_press || w_repeat;
    w_xfer      = r_valid && key_ready;
    w_valid_nxt = r_valid;
    w_code_nxt  = r_code;
    w_ovr_nxt   = 1'b0;
    if (w_fire) begin
      if (!r_valid || w_xfer) begin
        w_valid_nxt = 1'b1;
        w_code_nxt  = w_stable_code_nxt;
      end else begin
        w_ovr_nxt   = 1'b1;
      end
    end else if (w_xfer) begin
      w_valid_nxt = 1'b0;
    end else if (!r_valid && (r_stable_kind == SINGLE)) begin
      w_code_nxt  = r_stable_code;
    end else begin
      w_code_nxt  = r_code;
    end
  end

  // Handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_code  <= {KEY_CODE_W{1'b0}};
      r_ovr   <= 1'b0;
    end else begin
      r_valid <= w_valid_nxt;
      r_code  <= w_code_nxt;
      r_ovr   <= w_ovr_nxt;
    end
  end

  assign col_out   = r_col_out;
  assign key_code  = r_code;
  assign key_valid = r_valid;
  assign key_held  = r_held;
  assign multi_key = r_multi;
  assign overrun   = r_ovr;

endmodule

// File: tb/tb_keypad_encoder.sv
// -----------------------------------------------------------------------------
// tb_keypad_encoder
// Directed bench for keypad_encoder with SCAN_DIV=4, DEB_SCANS=2,
// REPEAT_SCANS=3 (sweep = 21 cycles). A behavioural keypad model pulls a row
// low whenever a pressed key sits on the currently driven column.
// -----------------------------------------------------------------------------
module tb_keypad_encoder;

  localparam int SWEEP = 21;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_ready = 1'b0;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic        multi_key;
  logic        overrun;
  logic [15:0] keys = 16'h0000;

  int checks = 0;
  int failures = 0;

  keypad_encoder #(
    .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEB_SCANS(2), .REPEAT_SCANS(3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_held  (key_held),
    .multi_key (multi_key),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Keypad matrix model: key index = row*4+col.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      row_in[r] = 1'b1;
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4 + c] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, output bit found);
    int n;
    n = 0;
    while (!key_valid && n < budget) begin
      tick();
      n++;
    end
    found = key_valid;
  endtask

  task automatic monitor(input int cycles, output int events, output int ovr,
                         output logic [3:0] code);
    events = 0;
    ovr = 0;
    code = 4'hF;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (key_valid) begin
        events++;
        code = key_code;
      end
      if (overrun) ovr++;
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    rst_n = 1'b0;
    keys = 16'h0000;
    repeat (3) tick();
    checks++; if (col_out !== 4'b1111) begin failures++; $display("FAIL reset_col_out got=%b exp=1111", col_out); end
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", key_valid); end
    checks++; if (key_code !== 4'd0) begin failures++; $display("FAIL reset_code got=%0d exp=0", key_code); end
    checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL reset_held got=%b exp=0", key_held); end
    checks++; if (multi_key !== 1'b0) begin failures++; $display("FAIL reset_multi got=%b exp=0", multi_key); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      exp_col = ~(4'b0001 << k);
      checks++;
      if (col_out !== exp_col) begin
        failures++;
        $display("FAIL scan_col%0d got=%b exp=%b", k, col_out, exp_col);
      end
      repeat (5) tick();
    end
    checks++; if (col_out !== 4'b1111) begin failures++; $display("FAIL scan_eval_col got=%b exp=1111", col_out); end
    tick();
    checks++; if (col_out !== 4'b1110) begin failures++; $display("FAIL scan_wrap_col got=%b exp=1110", col_out); end
  endtask

  task automatic test_press();
    bit found;
    int ev, ovr;
    logic [3:0] code;
    key_ready = 1'b0;
    keys = 16'h0001 << 9;
    wait_valid(3*SWEEP + 2, found);
    checks++; if (!found) begin failures++; $display("FAIL press_valid got=0 exp=1"); end
    checks++; if (key_code !== 4'd9) begin failures++; $display("FAIL press_code got=%0d exp=9", key_code); end
    checks++; if (key_held !== 1'b1) begin failures++; $display("FAIL press_held got=%b exp=1", key_held); end
    checks++; if (multi_key !== 1'b0) begin failures++; $display("FAIL press_multi got=%b exp=0", multi_key); end
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL press_xfer_valid got=%b exp=0", key_valid); end
`ifdef KEYPAD_REPEAT_EN
    wait_valid(3*SWEEP + 2, found);
    checks++; if (!found) begin failures++; $display("FAIL repeat_valid got=0 exp=1"); end
    checks++; if (key_code !== 4'd9) begin failures++; $display("FAIL repeat_code got=%0d exp=9", key_code); end
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
`else
    monitor(6*SWEEP, ev, ovr, code);
    checks++; if (ev != 0) begin failures++; $display("FAIL hold_no_event got=%0d exp=0", ev); end
`endif
    checks++; if (key_held !== 1'b1) begin failures++; $display("FAIL hold_held got=%b exp=1", key_held); end
    key_ready = 1'b1;
    keys = 16'h0000;
    monitor(3*SWEEP, ev, ovr, code);
    key_ready = 1'b0;
    checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL release_held got=%b exp=0", key_held); end
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL release_valid got=%b exp=0", key_valid); end
  endtask

  task automatic test_bounce();
    int ev_b, ev, ovr;
    logic [3:0] code;
    key_ready = 1'b1;
    ev_b = 0;
    for (int i = 0; i < 20; i++) begin
      keys = (i % 2 == 0) ? 16'h0001 : 16'h0000;
      repeat (3) begin
        tick();
        if (key_valid) ev_b++;
      end
    end
    keys = 16'h0001;
    monitor(4*SWEEP, ev, ovr, code);
    checks++; if (ev_b + ev != 1) begin failures++; $display("FAIL bounce_events got=%0d exp=1", ev_b + ev); end
    checks++; if (code !== 4'd0) begin failures++; $display("FAIL bounce_code got=%0d exp=0", code); end
    checks++; if (key_held !== 1'b1) begin failures++; $display("FAIL bounce_held got=%b exp=1", key_held); end
    keys = 16'h0000;
    monitor(3*SWEEP, ev, ovr, code);
    key_ready = 1'b0;
  endtask

  task automatic test_multi();
    int ev, ovr;
    logic [3:0] code;
    key_ready = 1'b1;
    keys = (16'h0001 << 4) | (16'h0001 << 7);
    monitor(4*SWEEP, ev, ovr, code);
    checks++; if (ev != 0) begin failures++; $display("FAIL multi_events got=%0d exp=0", ev); end
    checks++; if (multi_key !== 1'b1) begin failures++; $display("FAIL multi_flag got=%b exp=1", multi_key); end
    checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL multi_held got=%b exp=0", key_held); end
    keys = 16'h0001 << 4;
    monitor(4*SWEEP, ev, ovr, code);
    checks++; if (ev != 1) begin failures++; $display("FAIL multi_release_events got=%0d exp=1", ev); end
    checks++; if (code !== 4'd4) begin failures++; $display("FAIL multi_release_code got=%0d exp=4", code); end
    checks++; if (multi_key !== 1'b0) begin failures++; $display("FAIL multi_release_flag got=%b exp=0", multi_key); end
    checks++; if (key_held !== 1'b1) begin failures++; $display("FAIL multi_release_held got=%b exp=1", key_held); end
    keys = 16'h0000;
    monitor(3*SWEEP, ev, ovr, code);
    key_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit found;
    int ev, ovr;
    logic [3:0] code;
    key_ready = 1'b0;
    keys = 16'h0001 << 3;
    wait_valid(3*SWEEP + 2, found);
    checks++; if (!found) begin failures++; $display("FAIL bp_first_valid got=0 exp=1"); end
    checks++; if (key_code !== 4'd3) begin failures++; $display("FAIL bp_first_code got=%0d exp=3", key_code); end
    keys = 16'h0000;
    monitor(3*SWEEP, ev, ovr, code);
    checks++; if (ovr != 0) begin failures++; $display("FAIL bp_release_overrun got=%0d exp=0", ovr); end
    keys = 16'h0001 << 5;
    monitor(4*SWEEP, ev, ovr, code);
    checks++; if (ovr != 1) begin failures++; $display("FAIL bp_overrun_pulses got=%0d exp=1", ovr); end
    checks++; if (key_code !== 4'd3) begin failures++; $display("FAIL bp_code_kept got=%0d exp=3", key_code); end
    checks++; if (key_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_kept got=%b exp=1", key_valid); end
    checks++; if (key_held !== 1'b1) begin failures++; $display("FAIL bp_held got=%b exp=1", key_held); end
    key_ready = 1'b1;
    tick();
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL bp_xfer_valid got=%b exp=0", key_valid); end
    monitor(3*SWEEP, ev, ovr, code);
    checks++; if (ev != 0) begin failures++; $display("FAIL bp_no_code5_event got=%0d exp=0", ev); end
    checks++; if (key_code !== 4'd5) begin failures++; $display("FAIL bp_code_follows got=%0d exp=5", key_code); end
    keys = 16'h0000;
    monitor(3*SWEEP, ev, ovr, code);
    key_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    bit found;
    key_ready = 1'b0;
    keys = 16'h0001 << 9;
    wait_valid(3*SWEEP + 2, found);
    checks++; if (!found) begin failures++; $display("FAIL ar_valid_before got=0 exp=1"); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL ar_valid got=%b exp=0", key_valid); end
    checks++; if (col_out !== 4'b1111) begin failures++; $display("FAIL ar_col_out got=%b exp=1111", col_out); end
    checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL ar_held got=%b exp=0", key_held); end
    keys = 16'h0000;
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_multi();
    test_backpressure();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
